// File: rtl/laser_scan_ctrl.sv
// Laser scan controller: walks every candidate circle centre on a square grid,
// presenting each candidate's data banks in turn. Passes alternate between
// optimising circle 1 and circle 2. A STALL holds the presented tuple, and
// ABORT or reset abandons the run.
module laser_scan_ctrl #(
    parameter int GRID_MIN = 2,
    parameter int GRID_MAX = 13,
    parameter int N_BANKS  = 5,
    parameter int N_PASS   = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic       STALL,
    output logic       VALID,
    output logic [3:0] CX,
    output logic [3:0] CY,
    output logic [2:0] BANK,
    output logic       CIRCLE_SEL,
    output logic       ACC_CLR,
    output logic       CAND_END,
    output logic       PASS_END,
    output logic [2:0] PASS_CNT,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FIN
    } state_t;

    localparam logic [3:0] COORD_MIN = 4'(GRID_MIN);
    localparam logic [3:0] COORD_MAX = 4'(GRID_MAX);
    localparam logic [2:0] BANK_LAST = 3'(N_BANKS - 1);
    localparam logic [2:0] PASS_LAST = 3'(N_PASS - 1);

    state_t state;

    logic last_bank;
    logic row_end;
    logic col_end;
    logic last_pass;

    assign last_bank = (BANK == BANK_LAST);
    assign row_end   = (CX == COORD_MAX);
    assign col_end   = (CY == COORD_MAX);
    assign last_pass = (PASS_CNT == PASS_LAST);

    // The strobes depend only on registered state, so they remain asserted
    // for as long as a stall holds the tuple.
    assign ACC_CLR  = VALID && (BANK == 3'd0);
    assign CAND_END = VALID && last_bank;
    assign PASS_END = CAND_END && row_end && col_end;

    // Scan sequencer: bank -> CX -> CY -> pass counters, advanced on each transfer.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            VALID      <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            CX         <= 4'd0;
            CY         <= 4'd0;
            BANK       <= 3'd0;
            PASS_CNT   <= 3'd0;
            CIRCLE_SEL <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        state      <= SCAN;
                        VALID      <= 1'b1;
                        BUSY       <= 1'b1;
                        CX         <= COORD_MIN;
                        CY         <= COORD_MIN;
                        BANK       <= 3'd0;
                        PASS_CNT   <= 3'd0;
                        CIRCLE_SEL <= 1'b0;
                    end
                end
                SCAN: begin
                    if (ABORT) begin
                        state      <= IDLE;
                        VALID      <= 1'b0;
                        BUSY       <= 1'b0;
                        DONE       <= 1'b0;
                        CX         <= 4'd0;
                        CY         <= 4'd0;
                        BANK       <= 3'd0;
                        PASS_CNT   <= 3'd0;
                        CIRCLE_SEL <= 1'b0;
                    end else if (!STALL) begin
                        if (!last_bank) begin
                            BANK <= BANK + 3'd1;
                        end else begin
                            BANK <= 3'd0;
                            if (!row_end) begin
                                CX <= CX + 4'd1;
                            end else begin
                                CX <= COORD_MIN;
                                if (!col_end) begin
                                    CY <= CY + 4'd1;
                                end else begin
                                    CY <= COORD_MIN;
                                    if (last_pass) begin
                                        state      <= FIN;
                                        VALID      <= 1'b0;
                                        BUSY       <= 1'b0;
                                        DONE       <= 1'b1;
                                        CX         <= 4'd0;
                                        CY         <= 4'd0;
                                        PASS_CNT   <= 3'd0;
                                        CIRCLE_SEL <= 1'b0;
                                    end else begin
                                        PASS_CNT   <= PASS_CNT + 3'd1;
                                        CIRCLE_SEL <= ~CIRCLE_SEL;
                                    end
                                end
                            end
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    VALID <= 1'b0;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule
